// File: rtl/seq_normalizer.sv
// Iterative normaliser: shifts a word one bit per clock toward the chosen end
// until that end bit is 1, then reports the normalised word and the shift count.
module seq_normalizer #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [SHW-1:0]   shift_amt,
    output logic             zero
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] work_q,      work_d;
    logic             dir_q,       dir_d;
    logic [SHW-1:0]   count_q,     count_d;
    logic [WIDTH-1:0] data_out_q,  data_out_d;
    logic [SHW-1:0]   shift_amt_q, shift_amt_d;
    logic             zero_q,      zero_d;
    logic             out_valid_q, out_valid_d;
    logic             target_bit;

    assign target_bit = dir_q ? work_q[0] : work_q[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        dir_d       = dir_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        shift_amt_d = shift_amt_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = data_in;
                    dir_d   = dir;
                    count_d = '0;
                    // An all-zero word never reaches the target bit, so finish at once.
                    if (data_in == '0) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        zero_d      = 1'b1;
                        data_out_d  = '0;
                        shift_amt_d = '0;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (target_bit) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    data_out_d  = work_q;
                    shift_amt_d = count_q;
                    zero_d      = 1'b0;
                end else begin
                    work_d  = dir_q ? (work_q >> 1) : (work_q << 1);
                    count_d = count_q + SHW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            dir_q       <= 1'b0;
            count_q     <= '0;
            data_out_q  <= '0;
            shift_amt_q <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            dir_q       <= dir_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            shift_amt_q <= shift_amt_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign shift_amt = shift_amt_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed and round-trip testbench for seq_normalizer (WIDTH=8, SHW=3).
module tb_seq_normalizer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic       dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic [2:0] shift_amt;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    seq_normalizer #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .shift_amt (shift_amt),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Leading zeros counted from the end being normalised toward.
    function automatic int lead_zeros(input logic [7:0] v, input logic d);
        int n;
        n = 0;
        if (!d) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) break;
                n++;
            end
        end else begin
            for (int i = 0; i <= 7; i++) begin
                if (v[i]) break;
                n++;
            end
        end
        return n;
    endfunction

    // Issues one request (accept edge = edge 1) and waits for out_valid,
    // leaving the DUT in DONE. lat = 99 marks a timeout.
    task automatic run_req(input logic [7:0] d, input logic dr, output int lat);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        data_in  = d;
        dir      = dr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic finish_req();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; data_in = '0; dir = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hs: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        checks++;
        if (data_out !== 8'h00 || shift_amt !== 3'd0 || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_data: data_out=%h shift_amt=%0d zero=%b, expected 00 0 0",
                     data_out, shift_amt, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_left();
        int lat;
        run_req(8'b0001_0110, 1'b0, lat);
        checks++;
        if (lat !== 5 || data_out !== 8'b1011_0000 || shift_amt !== 3'd3 || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL left3: lat=%0d data_out=%b amt=%0d zero=%b, expected 5 10110000 3 0",
                     lat, data_out, shift_amt, zero);
        end
        finish_req();
        run_req(8'b1011_0011, 1'b0, lat);
        checks++;
        if (lat !== 2 || data_out !== 8'b1011_0011 || shift_amt !== 3'd0) begin
            failures++;
            $display("[TB] FAIL left0: lat=%0d data_out=%b amt=%0d, expected 2 10110011 0",
                     lat, data_out, shift_amt);
        end
        finish_req();
    endtask

    task automatic test_right();
        int lat;
        run_req(8'b1111_0000, 1'b1, lat);
        checks++;
        if (lat !== 6 || data_out !== 8'b0000_1111 || shift_amt !== 3'd4 || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL right4: lat=%0d data_out=%b amt=%0d zero=%b, expected 6 00001111 4 0",
                     lat, data_out, shift_amt, zero);
        end
        finish_req();
    endtask

    task automatic test_zero();
        int lat;
        for (int d = 0; d < 2; d++) begin
            run_req(8'h00, d[0], lat);
            checks++;
            if (lat !== 1 || zero !== 1'b1 || data_out !== 8'h00 || shift_amt !== 3'd0) begin
                failures++;
                $display("[TB] FAIL zero_dir%0d: lat=%0d zero=%b data_out=%h amt=%0d, expected 1 1 00 0",
                         d, lat, zero, data_out, shift_amt);
            end
            finish_req();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_req(8'b0000_0001, 1'b0, lat);
        checks++;
        if (lat !== 9 || data_out !== 8'b1000_0000 || shift_amt !== 3'd7) begin
            failures++;
            $display("[TB] FAIL max_shift: lat=%0d data_out=%b amt=%0d, expected 9 10000000 7",
                     lat, data_out, shift_amt);
        end
        for (int c = 0; c < 3; c++) begin
            data_in  = 8'h5A + 8'(c);
            dir      = 1'b1;
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 8'b1000_0000 ||
                shift_amt !== 3'd7 || zero !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_%0d: out_valid=%b in_ready=%b data_out=%b amt=%0d zero=%b, expected 1 0 10000000 7 0",
                         c, out_valid, in_ready, data_out, shift_amt, zero);
            end
        end
        in_valid = 1'b0;
        finish_req();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        checks++;
        if (data_out !== 8'b1000_0000 || shift_amt !== 3'd7) begin
            failures++;
            $display("[TB] FAIL post_hold: data_out=%b amt=%0d, expected 10000000 7", data_out, shift_amt);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bit seen;
        data_in  = 8'b0000_0001;
        dir      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h00 ||
            shift_amt !== 3'd0 || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_rst: in_ready=%b out_valid=%b data_out=%h amt=%0d zero=%b, expected 1 0 00 0 0",
                     in_ready, out_valid, data_out, shift_amt, zero);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abandoned: out_valid seen=%b, expected 0", seen);
        end
        run_req(8'b0100_0000, 1'b0, lat);
        checks++;
        if (lat !== 3 || data_out !== 8'b1000_0000 || shift_amt !== 3'd1) begin
            failures++;
            $display("[TB] FAIL after_rst: lat=%0d data_out=%b amt=%0d, expected 3 10000000 1",
                     lat, data_out, shift_amt);
        end
        finish_req();
    endtask

    task automatic test_round_trip();
        int lat;
        int k;
        logic [7:0] d;
        logic       dr;
        logic [7:0] back;
        for (int n = 0; n < 500; n++) begin
            d  = 8'($urandom_range(255, 1));
            dr = 1'($urandom_range(1, 0));
            k  = lead_zeros(d, dr);
            run_req(d, dr, lat);
            back = dr ? (data_out << shift_amt) : (data_out >> shift_amt);
            checks++;
            if (back !== d || int'(shift_amt) !== k || lat !== k + 2 || zero !== 1'b0) begin
                failures++;
                $display("[TB] FAIL round_trip_%0d: in=%b dir=%b out=%b amt=%0d lat=%0d back=%b, expected amt=%0d lat=%0d back=%b",
                         n, d, dr, data_out, shift_amt, lat, back, k, k + 2, d);
            end
            finish_req();
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_zero();
        test_backpressure();
        test_reset_mid_shift();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
